// File: rtl/kmeans_centroid_update_k4n2.sv
// Divides the 4x2 accumulator sums by their sample counts and writes each new centroid.
// Build option KMEANS_UPD_ROUND_EN: round to nearest (sum + count/2, one extra divide cycle).
module kmeans_centroid_update_k4n2 #(
  parameter int input_data_width         = 8,
  parameter int input_data_qty_bit_width = 8,
  parameter int acc_width                = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                rd_acc_en,
  output logic [1:0]                          rd_acc_centroid,
  input  logic [acc_width-1:0]                acc0_in,
  input  logic [acc_width-1:0]                acc1_in,
  input  logic [input_data_qty_bit_width-1:0] acc_count_in,
  output logic                                new_centroid_wr,
  output logic [1:0]                          new_centroid_idx,
  output logic [input_data_width-1:0]         new_centroid_d0,
  output logic [input_data_width-1:0]         new_centroid_d1,
  output logic [3:0]                          empty_mask
);

`ifdef KMEANS_UPD_ROUND_EN
  localparam int DW = acc_width + 1;
`else
  localparam int DW = acc_width;
`endif
  localparam int QW = input_data_qty_bit_width;
  localparam int IW = input_data_width;
  localparam int CW = $clog2(DW + 1);

  // NEXT costs no cycle, so it lives only in the READ/WRITE transitions.
  typedef enum logic [2:0] {S_IDLE, S_READ, S_DIV, S_WRITE, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_k;
  logic [CW-1:0]   r_cnt;
  logic [QW-1:0]   r_div;
  logic [DW-1:0]   r_dvd [2];
  logic [DW-1:0]   r_q   [2];
  logic [QW-1:0]   r_rem [2];
  logic [3:0]      r_mask;
  logic [IW-1:0]   r_d0, r_d1;
  logic [1:0]      r_idx;

  logic [DW-1:0]   w_dvd   [2];
  logic [QW:0]     w_trial [2];
  logic [QW:0]     w_sub   [2];
  logic            w_ge    [2];
  logic [QW-1:0]   w_rem_n [2];
  logic [DW-1:0]   w_q_n   [2];
  logic            w_empty, w_last;

  assign w_empty = (acc_count_in == '0);
  assign w_last  = (r_cnt == CW'(DW - 1));

`ifdef KMEANS_UPD_ROUND_EN
  assign w_dvd[0] = {1'b0, acc0_in} + DW'(acc_count_in >> 1);
  assign w_dvd[1] = {1'b0, acc1_in} + DW'(acc_count_in >> 1);
`else
  assign w_dvd[0] = acc0_in;
  assign w_dvd[1] = acc1_in;
`endif

  // Restoring step: the remainder stays below the divisor, so QW bits hold it.
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      w_trial[d] = {r_rem[d], r_dvd[d][DW-1]};
      w_ge[d]    = (w_trial[d] >= {1'b0, r_div});
      w_sub[d]   = w_trial[d] - {1'b0, r_div};
      w_rem_n[d] = w_ge[d] ? w_sub[d][QW-1:0] : w_trial[d][QW-1:0];
      w_q_n[d]   = {r_q[d][DW-2:0], w_ge[d]};
    end
  end

  function automatic logic [IW-1:0] sat(input logic [DW-1:0] q);
    return (|q[DW-1:IW]) ? {IW{1'b1}} : q[IW-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    busy            = (r_state != S_IDLE);
    done            = 1'b0;
    rd_acc_en       = 1'b0;
    rd_acc_centroid = r_k;
    new_centroid_wr = 1'b0;
    case (r_state)
      S_IDLE: begin
        rd_acc_centroid = 2'd0;
        if (start) w_next = S_READ;
      end
      S_READ: begin
        rd_acc_en = 1'b1;
        if (!w_empty)          w_next = S_DIV;
        else if (r_k == 2'd3)  w_next = S_DONE;
        else                   w_next = S_READ;
      end
      S_DIV: if (w_last) w_next = S_WRITE;
      S_WRITE: begin
        new_centroid_wr = 1'b1;
        w_next = (r_k == 2'd3) ? S_DONE : S_READ;
      end
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_k    <= '0;
      r_cnt  <= '0;
      r_div  <= '0;
      r_mask <= '0;
      r_d0   <= '0;
      r_d1   <= '0;
      r_idx  <= '0;
      for (int d = 0; d < 2; d++) begin
        r_dvd[d] <= '0;
        r_q[d]   <= '0;
        r_rem[d] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_k    <= '0;
          r_mask <= '0;
        end
        S_READ: begin
          r_div <= acc_count_in;
          r_cnt <= '0;
          for (int d = 0; d < 2; d++) begin
            r_dvd[d] <= w_dvd[d];
            r_q[d]   <= '0;
            r_rem[d] <= '0;
          end
          if (w_empty) begin
            r_mask[r_k] <= 1'b1;
            if (r_k != 2'd3) r_k <= r_k + 2'd1;
          end
        end
        S_DIV: begin
          r_cnt <= r_cnt + CW'(1);
          for (int d = 0; d < 2; d++) begin
            r_dvd[d] <= r_dvd[d] << 1;
            r_rem[d] <= w_rem_n[d];
            r_q[d]   <= w_q_n[d];
          end
          // Result registers load on the final step so they are valid through WRITE.
          if (w_last) begin
            r_d0  <= sat(w_q_n[0]);
            r_d1  <= sat(w_q_n[1]);
            r_idx <= r_k;
          end
        end
        S_WRITE: if (r_k != 2'd3) r_k <= r_k + 2'd1;
        default: ;
      endcase
    end
  end

  assign new_centroid_idx = r_idx;
  assign new_centroid_d0  = r_d0;
  assign new_centroid_d1  = r_d1;
  assign empty_mask       = r_mask;

endmodule

// File: tb/tb_kmeans_centroid_update_k4n2.sv
// Bench for kmeans_centroid_update_k4n2: behavioural accumulator read port plus a write scoreboard.
module tb_kmeans_centroid_update_k4n2;

`ifdef KMEANS_UPD_ROUND_EN
  localparam int DW = 17;
`else
  localparam int DW = 16;
`endif

  logic        clk = 1'b0;
  logic        rst, start;
  logic        busy, done, rd_acc_en, new_centroid_wr;
  logic [1:0]  rd_acc_centroid, new_centroid_idx;
  logic [15:0] acc0_in, acc1_in;
  logic [7:0]  acc_count_in, new_centroid_d0, new_centroid_d1;
  logic [3:0]  empty_mask;

  logic [15:0] m_s0 [4];
  logic [15:0] m_s1 [4];
  logic [7:0]  m_c  [4];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign acc0_in      = m_s0[rd_acc_centroid];
  assign acc1_in      = m_s1[rd_acc_centroid];
  assign acc_count_in = m_c[rd_acc_centroid];

  kmeans_centroid_update_k4n2 #(
    .input_data_width(8), .input_data_qty_bit_width(8), .acc_width(16)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_acc_en(rd_acc_en), .rd_acc_centroid(rd_acc_centroid),
    .acc0_in(acc0_in), .acc1_in(acc1_in), .acc_count_in(acc_count_in),
    .new_centroid_wr(new_centroid_wr), .new_centroid_idx(new_centroid_idx),
    .new_centroid_d0(new_centroid_d0), .new_centroid_d1(new_centroid_d1),
    .empty_mask(empty_mask)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] exp_q(input logic [15:0] s, input logic [7:0] c);
    logic [16:0] dv, q;
    dv = {1'b0, s};
`ifdef KMEANS_UPD_ROUND_EN
    dv = dv + 17'(c >> 1);
`endif
    q = dv / {9'd0, c};
    return (q > 17'd255) ? 8'hff : q[7:0];
  endfunction

  task automatic set_k(input int k, input int s0, input int s1, input int c);
    m_s0[k] = 16'(s0);
    m_s1[k] = 16'(s1);
    m_c[k]  = 8'(c);
  endtask

  task automatic set_basic();
    set_k(0, 100, 50, 10);
    set_k(1, 40, 80, 4);
    set_k(2, 9, 9, 3);
    set_k(3, 255, 0, 1);
  endtask

  task automatic check_reset_outs(input string pfx);
    check({pfx, "_busy"},  32'(busy), 0);
    check({pfx, "_done"},  32'(done), 0);
    check({pfx, "_rden"},  32'(rd_acc_en), 0);
    check({pfx, "_rdidx"}, 32'(rd_acc_centroid), 0);
    check({pfx, "_wr"},    32'(new_centroid_wr), 0);
    check({pfx, "_widx"},  32'(new_centroid_idx), 0);
    check({pfx, "_d0"},    32'(new_centroid_d0), 0);
    check({pfx, "_d1"},    32'(new_centroid_d1), 0);
    check({pfx, "_mask"},  32'(empty_mask), 0);
  endtask

  // busy_cyc: cycle in which a second start is pulsed (0 = none); rst_cyc: cycle to assert rst (0 = none).
  task automatic run_pass(input int busy_cyc, input int rst_cyc);
    logic [17:0] sb[$];
    logic [17:0] e, last_e;
    int          exp_done, n_exp, n_done;
    logic [3:0]  exp_mask;
    bit          fin;
    exp_done = 1;
    exp_mask = '0;
    n_done   = 0;
    fin      = 0;
    last_e   = '0;
    for (int k = 0; k < 4; k++) begin
      if (m_c[k] == 8'd0) begin
        exp_mask[k] = 1'b1;
        exp_done += 1;
      end else begin
        sb.push_back({2'(k), exp_q(m_s0[k], m_c[k]), exp_q(m_s1[k], m_c[k])});
        exp_done += DW + 2;
      end
    end
    n_exp = sb.size();

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int n = 1; n <= 300 && !fin; n++) begin
      @(negedge clk);
      start = (n == busy_cyc);
      if (n == 1) begin
        check("read0_busy",  32'(busy), 1);
        check("read0_rden",  32'(rd_acc_en), 1);
        check("read0_rdidx", 32'(rd_acc_centroid), 0);
      end
      if (new_centroid_wr) begin
        if (sb.size() == 0) check("wr_unexpected", 32'(new_centroid_wr), 0);
        else begin
          e = sb.pop_front();
          last_e = e;
          check("wr_idx", 32'(new_centroid_idx), 32'(e[17:16]));
          check("wr_d0",  32'(new_centroid_d0),  32'(e[15:8]));
          check("wr_d1",  32'(new_centroid_d1),  32'(e[7:0]));
        end
      end
      if (done) begin
        n_done++;
        check("done_cycle",   32'(n), 32'(exp_done));
        check("done_mask",    32'(empty_mask), 32'(exp_mask));
        check("done_busy",    32'(busy), 1);
        fin = 1;
      end
      if (n == rst_cyc) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check_reset_outs("rst_mid");
        check("rst_no_write", 32'(sb.size()), 32'(n_exp));
        return;
      end
    end
    start = 1'b0;
    if (!fin) check("done_timeout", 32'(done), 1);
    check("writes_missing", 32'(sb.size()), 0);
    repeat (3) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 0);
      if (done) n_done++;
      if (new_centroid_wr) check("wr_after_done", 32'(new_centroid_wr), 0);
    end
    check("done_count", 32'(n_done), 1);
    check("mask_hold",  32'(empty_mask), 32'(exp_mask));
    if (n_exp > 0) begin
      check("d0_hold", 32'(new_centroid_d0), 32'(last_e[15:8]));
      check("d1_hold", 32'(new_centroid_d1), 32'(last_e[7:0]));
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    set_basic();
    repeat (3) @(negedge clk);
    check_reset_outs("por");
    rst = 1'b0;

    run_pass(0, 0);

    set_k(0, 15, 14, 4);
    run_pass(0, 0);

    set_basic();
    set_k(2, 9, 9, 0);
    run_pass(0, 0);

    set_basic();
    set_k(1, 4000, 300, 1);
    set_k(2, 510, 0, 2);
    run_pass(0, 0);

    set_basic();
    run_pass(0, 5);
    run_pass(0, 0);

    run_pass(10, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
